// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and depth.
// Latency: pure functions, no state.
// Backpressure: not applicable; used by both write- and read-domain controllers.
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend narrower pointers.
    localparam int PTR_MAX_W = 32;

    // Number of RAM entries addressed by aw address bits.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Binary to Gray over the low w bits; bits above w come back as zero.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                      input int w);
        logic [PTR_MAX_W-1:0] m;
        m = b;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            if (i >= w) m[i] = 1'b0;
        end
        return m ^ (m >> 1);
    endfunction

    // Gray to binary over the low w bits; each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                      input int w);
        logic [PTR_MAX_W-1:0] m;
        logic [PTR_MAX_W-1:0] b;
        m = g;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            if (i >= w) m[i] = 1'b0;
        end
        b[PTR_MAX_W-1] = m[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ m[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_sync.sv
// Multi-flop synchroniser chain with synchronous reset, for Gray pointers crossing clock domains.
// Latency: STAGES destination-clock edges from d to q.
// Backpressure: none; samples every edge.
module sync_nff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous input through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q     = stage[STAGES-1];
    // Value the last stage captures on the coming edge, so consumers can register flags without extra delay.
    assign q_nxt = stage[STAGES-2];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: write pointer, synchronised read pointer, full/almost_full/level/overflow.
// Latency: wr_ack combinational; flags registered on the accepting edge; read-side changes seen SYNC_STAGES edges later.
// Backpressure: wr_ack drops while full; a refused write sets sticky overflow until cleared.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic                  clr_overflow,
    input  logic [ADDR_WIDTH:0]   rd_gray_ptr,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray_ptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgray;
    logic [PW-1:0] wbin_nxt;
    logic [PW-1:0] wgray_nxt;
    logic [PW-1:0] rq_gray;
    logic [PW-1:0] rq_gray_nxt;
    logic [PW-1:0] rq_bin_nxt;
    logic [PW-1:0] level_nxt;
    logic          full_nxt;
    logic          af_nxt;

    // Read pointer stays in Gray until it has crossed into this domain.
    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rq_sync (
        .clk   (wr_clk),
        .rst   (wr_rst),
        .d     (rd_gray_ptr),
        .q     (rq_gray),
        .q_nxt (rq_gray_nxt)
    );

    assign wr_ack = wr_en && !full;

    // Next-state pointer and flags use the read pointer the synchroniser presents on this edge,
    // so a write and a read-side update in the same cycle are both reflected immediately.
    always_comb begin
        wbin_nxt   = wbin + {{ADDR_WIDTH{1'b0}}, wr_ack};
        wgray_nxt  = PW'(bin2gray(PTR_MAX_W'(wbin_nxt), PW));
        rq_bin_nxt = PW'(gray2bin(PTR_MAX_W'(rq_gray_nxt), PW));
        level_nxt  = wbin_nxt - rq_bin_nxt;
        full_nxt   = (wgray_nxt == {~rq_gray_nxt[PW-1:PW-2], rq_gray_nxt[PW-3:0]});
        af_nxt     = (level_nxt >= AF_THRESH);
    end

    // Pointer and status registers; reset overrides any write in flight.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wbin        <= wbin_nxt;
            wgray       <= wgray_nxt;
            full        <= full_nxt;
            almost_full <= af_nxt;
            wr_level    <= level_nxt;
        end
    end

    // Sticky overflow: a refused write wins over a same-cycle clear.
    always_ff @(posedge wr_clk) begin
        if (wr_rst)              overflow <= 1'b0;
        else if (wr_en && full)  overflow <= 1'b1;
        else if (clr_overflow)   overflow <= 1'b0;
    end

    assign wr_addr     = wbin[ADDR_WIDTH-1:0];
    assign wr_gray_ptr = wgray;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic       clr_overflow;
    logic [3:0] rd_gray_ptr;
    logic       wr_ack;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray_ptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AF_MARGIN   (2)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .wr_en        (wr_en),
        .clr_overflow (clr_overflow),
        .rd_gray_ptr  (rd_gray_ptr),
        .wr_ack       (wr_ack),
        .wr_addr      (wr_addr),
        .wr_gray_ptr  (wr_gray_ptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it, inputs changed there too.
    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        logic [3:0] g;
        // ---------------- reset with random inputs ----------------
        wr_rst       = 1'b1;
        wr_en        = 1'($urandom);
        clr_overflow = 1'($urandom);
        rd_gray_ptr  = 4'($urandom);
        step();
        wr_en        = 1'($urandom);
        clr_overflow = 1'($urandom);
        rd_gray_ptr  = 4'($urandom);
        step();
        #1;
        check("rst_full",     full,        0);
        check("rst_af",       almost_full, 0);
        check("rst_level",    wr_level,    0);
        check("rst_ovf",      overflow,    0);
        check("rst_gray",     wr_gray_ptr, 0);
        check("rst_addr",     wr_addr,     0);
        check("rst_ack",      wr_ack,      wr_en);

        wr_rst = 1'b0; wr_en = 1'b0; clr_overflow = 1'b0; rd_gray_ptr = 4'b0000;
        step();
        check("idle_level", wr_level, 0);

        // ---------------- fill 8 entries ----------------
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            #1;
            check("fill_ack", wr_ack, 1);
            step();
            check("fill_level", wr_level, i);
            check("fill_af",    almost_full, (i >= 6) ? 1 : 0);
            check("fill_full",  full,        (i == 8) ? 1 : 0);
        end
        check("fill_gray", wr_gray_ptr, 4'b1100);

        // ---------------- overflow ----------------
        #1;
        check("ovf_ack", wr_ack, 0);
        step();
        check("ovf_set",  overflow,    1);
        check("ovf_gray", wr_gray_ptr, 4'b1100);
        check("ovf_addr", wr_addr,     0);
        check("ovf_full", full,        1);
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ovf_hold", overflow, 1);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);

        // ---------------- drain visibility ----------------
        rd_gray_ptr = 4'b0011;
        step();
        check("drain_full_e1", full, 1);
        step();
        check("drain_full_e2", full,        0);
        check("drain_level6",  wr_level,    6);
        check("drain_af6",     almost_full, 1);
        rd_gray_ptr = 4'b0010;
        step();
        step();
        check("drain_level5", wr_level,    5);
        check("drain_af5",    almost_full, 0);

        // ---------------- refill, overflow, then reset mid-operation ----------------
        wr_en = 1'b1;
        step(); check("refill_l6", wr_level, 6);
        step(); check("refill_l7", wr_level, 7);
        step(); check("refill_l8", wr_level, 8);
        check("refill_full", full, 1);
        check("refill_gray", wr_gray_ptr, 4'b1110);
        step();
        check("refill_ovf", overflow, 1);
        wr_rst = 1'b1;
        rd_gray_ptr = 4'b0000;
        step();
        check("mrst_full",  full,        0);
        check("mrst_af",    almost_full, 0);
        check("mrst_level", wr_level,    0);
        check("mrst_ovf",   overflow,    0);
        check("mrst_gray",  wr_gray_ptr, 0);
        check("mrst_addr",  wr_addr,     0);
        wr_rst = 1'b0;
        wr_en  = 1'b0;
        step();

        // ---------------- wrap with read pointer trailing ----------------
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1;
            g = 4'(k) ^ (4'(k) >> 1);
            rd_gray_ptr = g;
            step();
            check("wrap_full", full, 0);
            checks++;
            assert (wr_level <= 4'd2) else begin
                failures++;
                $error("FAIL wrap_level observed=%0d expected<=2", wr_level);
            end
            if (k == 6)  check("wrap_addr7",  wr_addr, 7);
            if (k == 7)  check("wrap_addr0",  wr_addr, 0);
            if (k == 14) check("wrap_gray15", wr_gray_ptr, 4'b1000);
            if (k == 15) begin
                check("wrap_gray0", wr_gray_ptr, 4'b0000);
                check("wrap_addr_w", wr_addr, 0);
            end
        end
        wr_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
